// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry type for the instruction fetch queue.
// Widths here are the default 32-bit configuration.
package fetch_queue_pkg;

  localparam int          FETCHQ_DEPTH_DEFAULT    = 4;
  localparam int          FETCHQ_AWIDTH_DEFAULT   = 32;
  localparam int          FETCHQ_DWIDTH_DEFAULT   = 32;
  localparam logic [31:0] FETCHQ_BASEADDR_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] ECALL_INSN              = 32'h0000_0073;

  typedef struct packed {
    logic [FETCHQ_AWIDTH_DEFAULT-1:0] pc;
    logic [FETCHQ_DWIDTH_DEFAULT-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetchq_fifo: circular entry store with push/pop/flush and occupancy count.
// Head is read combinationally; the caller guarantees no push when full without a pop.
module fetchq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = FETCHQ_DEPTH_DEFAULT,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction fetch with in-order response queue, redirect flush and stale-response discard.
// Optional FETCHQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                AWIDTH   = FETCHQ_AWIDTH_DEFAULT,
  parameter int                DWIDTH   = FETCHQ_DWIDTH_DEFAULT,
  parameter int                DEPTH    = FETCHQ_DEPTH_DEFAULT,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] dec_pc_o,
  output logic [DWIDTH-1:0] dec_insn_o
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] rsp_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic              empty;
  logic              flush;
  logic              rsp_live;
  logic              bypass;
  logic              push;
  logic              pop;
  entry_t            head;
  entry_t            rsp_entry;
  entry_t            dec_entry;

  assign flush    = rst | redirect_i;
  assign rsp_live = imem_rsp_valid_i && (discard == '0) && !flush;

  // Outstanding requests include ones already marked for discard, so the credit stays exact.
  assign imem_req_o  = !flush && (({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(DEPTH));
  assign imem_addr_o = fetch_pc;

  assign rsp_entry = '{pc: rsp_pc, insn: imem_rsp_data_i};

`ifdef FETCHQ_BYPASS_EN
  assign bypass = empty && rsp_live;
`else
  assign bypass = 1'b0;
`endif

  assign dec_entry   = bypass ? rsp_entry : head;
  assign dec_valid_o = !rst && (!empty || bypass);
  assign dec_pc_o    = dec_entry.pc;
  assign dec_insn_o  = dec_entry.insn;

  assign pop  = !flush && dec_ready_i && !empty;
  assign push = rsp_live && !(bypass && dec_ready_i);

  // Responses return in request order with no gaps, so the next live response PC is a running count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= BASEADDR;
      rsp_pc   <= BASEADDR;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      rsp_pc   <= redirect_pc_i;
    end else begin
      if (imem_req_o) fetch_pc <= fetch_pc + AWIDTH'(4);
      if (rsp_live)   rsp_pc   <= rsp_pc + AWIDTH'(4);
    end
  end

  // Reset keeps the outstanding count so responses to pre-reset requests are still dropped.
  always_ff @(posedge clk) begin
    inflight <= inflight + CW'(imem_req_o) - CW'(imem_rsp_valid_i);
    if (flush) begin
      discard <= inflight - CW'(imem_rsp_valid_i);
    end else if (imem_rsp_valid_i && (discard != '0)) begin
      discard <= discard - CW'(1);
    end
  end

  fetchq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, checked against a queue-based model
// with an in-order memory whose outstanding requests carry a stale flag.
module tb_fetch_queue;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_insn_o;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .dec_pc_o         (dec_pc_o),
    .dec_insn_o       (dec_insn_o)
  );

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  pend_t       pend[$];
  ent_t        q[$];
  logic [31:0] m_pc = BASE;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        o_req;
  logic        o_dv;
  logic [31:0] o_pc;
  logic [31:0] o_insn;
  bit          o_live;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt, input bit r, input int lat);
    bit    rv, live, ebyp, ereq, edv;
    ent_t  eh;
    pend_t p;
    rv   = (pend.size() > 0) && (pend[0].due <= cyc);
    live = rv && !pend[0].stale && !r && !redir;
    rst              = r;
    redirect_i       = redir;
    redirect_pc_i    = tgt;
    dec_ready_i      = rdy;
    imem_rsp_valid_i = rv;
    imem_rsp_data_i  = rv ? insn_of(pend[0].pc) : 32'h0;
    ereq = !r && !redir && ((q.size() + pend.size()) < DEPTH);
`ifdef FETCHQ_BYPASS_EN
    ebyp = live && (q.size() == 0);
`else
    ebyp = 1'b0;
`endif
    edv = !r && ((q.size() > 0) || ebyp);
    eh  = '{pc: 32'h0, insn: 32'h0};
    if (ebyp) eh = '{pc: pend[0].pc, insn: insn_of(pend[0].pc)};
    else if (q.size() > 0) eh = q[0];

    @(negedge clk);
    o_req  = imem_req_o;
    o_dv   = dec_valid_o;
    o_pc   = dec_pc_o;
    o_insn = dec_insn_o;
    o_live = live;
    chk("imem_req", {31'b0, imem_req_o}, {31'b0, ereq});
    chk("imem_addr", imem_addr_o, m_pc);
    chk("dec_valid", {31'b0, dec_valid_o}, {31'b0, edv});
    if (edv) begin
      chk("dec_pc", dec_pc_o, eh.pc);
      chk("dec_insn", dec_insn_o, eh.insn);
    end

    @(posedge clk);
    p = '{pc: 32'h0, stale: 1'b0, due: 0};
    if (rv) p = pend.pop_front();
    if (r || redir) begin
      q.delete();
      foreach (pend[k]) pend[k].stale = 1'b1;
      m_pc = r ? BASE : tgt;
    end else begin
      if (ebyp) begin
        if (!rdy) q.push_back('{pc: p.pc, insn: insn_of(p.pc)});
      end else begin
        if (edv && rdy) q.delete(0);
        if (live) q.push_back('{pc: p.pc, insn: insn_of(p.pc)});
      end
      if (ereq) begin
        pend.push_back('{pc: m_pc, stale: 1'b0, due: cyc + lat});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs[$];
    int          at[$];
    int          nreq;
    int          stale_seen;
    int          first_live;
    int          first_dv;
    bit          rdy, redir, r;
    logic [31:0] tgt;

    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; dec_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    @(posedge clk); #1;

    // Reset state, then a 1-cycle memory streaming into an always-ready decoder.
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, 1);
      if (o_dv) begin pcs.push_back(o_pc); at.push_back(cyc - 1); end
    end
    chk("stream_pc0", pcs[0], BASE);
    chk("stream_pc1", pcs[1], BASE + 32'd4);
    chk("stream_pc2", pcs[2], BASE + 32'd8);
    chk("stream_consecutive", 32'(at[2] - at[0]), 32'd2);

    // Decoder stalled: credit limits requests to DEPTH and the head holds.
    cycle(0, 0, 0, 1, 1);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (o_req) nreq++;
    end
    chk("stall_reqs", 32'(nreq), 32'(DEPTH));
    chk("stall_valid", {31'b0, o_dv}, 32'd1);
    chk("stall_head", o_pc, BASE);

    // Drain from full with refill running: order preserved, no bubbles.
    pcs.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, 1);
      if (o_dv) pcs.push_back(o_pc);
    end
    chk("drain_pops", 32'(pcs.size()), 32'd10);
    foreach (pcs[i]) chk("drain_order", pcs[i], BASE + 32'(i * 4));

    // Redirect with three requests outstanding.
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 3);
    cycle(1, 1, 32'h0100_0100, 0, 3);
    pcs.delete(); stale_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0, 0, 1);
      if (o_dv) begin
        if (pcs.size() == 0) chk("redir_first_insn", o_insn, insn_of(32'h0100_0100));
        pcs.push_back(o_pc);
        if (o_pc < 32'h0100_0100) stale_seen++;
      end
    end
    chk("redir_first_pc", pcs[0], 32'h0100_0100);
    chk("redir_no_stale", 32'(stale_seen), 32'd0);

    // Reset with two requests outstanding.
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 3);
    cycle(1, 0, 0, 0, 3);
    cycle(1, 0, 0, 1, 3);
    pcs.delete();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0, 0, 1);
      if (o_dv) begin
        if (pcs.size() == 0) chk("rst_first_insn", o_insn, insn_of(BASE));
        pcs.push_back(o_pc);
      end
    end
    chk("rst_first_pc", pcs[0], BASE);

    // Response-to-decode latency on an empty queue.
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    first_live = -1; first_dv = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0, 1);
      if (o_live && first_live < 0) first_live = cyc - 1;
      if (o_dv && first_dv < 0) first_dv = cyc - 1;
    end
`ifdef FETCHQ_BYPASS_EN
    chk("bypass_latency", 32'(first_dv - first_live), 32'd0);
`else
    chk("push_latency", 32'(first_dv - first_live), 32'd1);
`endif

    // Random traffic: stalls, random latency, redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      rdy   = ((i % 200) < 40) ? 1'b0 : ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 49) == 0);
      r     = ($urandom_range(0, 199) == 0);
      tgt   = 32'h0200_0000 + 32'($urandom_range(0, 4095)) * 32'd4;
      cycle(rdy, redir, tgt, r, $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
